// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external 16-bit combinational ALU between two requesters.
// An accepted request has its operands and op code registered. The ALU is
// driven from those registers for one execute cycle. The ALU result and zero
// flag are then captured and held until the granted requester takes them.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin between the ports on a tie
//                  undefined -> fixed priority; port 0 wins every tie
//
// Ports (x = 0, 1):
//   clk, reset              clock, synchronous active-high reset
//   req_valid_x/req_ready_x request handshake
//   req_a_x, req_b_x        operands (N bits)
//   req_op_x                ALU control code (3 bits)
//   resp_valid_x/ready_x    response handshake
//   resp_result_x           captured ALU result (shared register)
//   resp_zero_x             captured ALU zero flag (shared register)
//   alu_a, alu_b            registered ALU operand drive
//   alu_control             registered ALU control drive
//   alu_result, alu_zero    combinational ALU outputs
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a request; grant computed from req_valid_x
// EXEC  | ALU driven from the operand registers; result captured
// RESP  | result held for the granted port until resp_ready
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req_valid_0,
    output logic         req_ready_0,
    input  logic [N-1:0] req_a_0,
    input  logic [N-1:0] req_b_0,
    input  logic [2:0]   req_op_0,
    output logic         resp_valid_0,
    input  logic         resp_ready_0,
    output logic [N-1:0] resp_result_0,
    output logic         resp_zero_0,

    input  logic         req_valid_1,
    output logic         req_ready_1,
    input  logic [N-1:0] req_a_1,
    input  logic [N-1:0] req_b_1,
    input  logic [2:0]   req_op_1,
    output logic         resp_valid_1,
    input  logic         resp_ready_1,
    output logic [N-1:0] resp_result_1,
    output logic         resp_zero_1,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic           grant_win;   // port that would win arbitration now
    logic           grant_q;     // port owning the transaction in flight
    logic           req_hs;
    logic           resp_hs;

    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [2:0]     op_q;
    logic [N-1:0]   result_q;
    logic           zero_q;

`ifdef ALU_ARB_RR_EN
    logic           last_grant;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        if (req_valid_0 && req_valid_1) begin
            grant_win = ~last_grant;
        end else begin
            grant_win = ~req_valid_0;
        end
    end
`else
    always_comb begin
        grant_win = ~req_valid_0;
    end
`endif

    // Next state and handshake outputs
    always_comb begin
        state_next   = state;
        req_ready_0  = 1'b0;
        req_ready_1  = 1'b0;
        resp_valid_0 = 1'b0;
        resp_valid_1 = 1'b0;
        req_hs       = 1'b0;
        resp_hs      = 1'b0;

        case (state)
            IDLE: begin
                req_ready_0 = req_valid_0 && !grant_win;
                req_ready_1 = req_valid_1 &&  grant_win;
                req_hs      = req_ready_0 || req_ready_1;
                if (req_hs) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid_0 = !grant_q;
                resp_valid_1 =  grant_q;
                resp_hs      = grant_q ? resp_ready_1 : resp_ready_0;
                if (resp_hs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            grant_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (req_hs) begin
                a_q     <= grant_win ? req_a_1  : req_a_0;
                b_q     <= grant_win ? req_b_1  : req_b_0;
                op_q    <= grant_win ? req_op_1 : req_op_0;
                grant_q <= grant_win;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

`ifdef ALU_ARB_RR_EN
    // Reset to 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (resp_hs) begin
            last_grant <= grant_q;
        end
    end
`endif

    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_control   = op_q;

    // Both ports see the same capture registers; resp_valid_x qualifies them.
    assign resp_result_0 = result_q;
    assign resp_result_1 = result_q;
    assign resp_zero_0   = zero_q;
    assign resp_zero_1   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  resp_ready = 2'b00;
    logic [15:0] req_a [2];
    logic [15:0] req_b [2];
    logic [2:0]  req_op [2];

    wire         req_ready_0, req_ready_1;
    wire         resp_valid_0, resp_valid_1;
    wire  [15:0] resp_result_0, resp_result_1;
    wire         resp_zero_0, resp_zero_1;
    wire  [15:0] alu_a, alu_b;
    wire  [2:0]  alu_control;
    logic [15:0] alu_result;
    logic        alu_zero;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_0   (req_valid[0]),
        .req_ready_0   (req_ready_0),
        .req_a_0       (req_a[0]),
        .req_b_0       (req_b[0]),
        .req_op_0      (req_op[0]),
        .resp_valid_0  (resp_valid_0),
        .resp_ready_0  (resp_ready[0]),
        .resp_result_0 (resp_result_0),
        .resp_zero_0   (resp_zero_0),
        .req_valid_1   (req_valid[1]),
        .req_ready_1   (req_ready_1),
        .req_a_1       (req_a[1]),
        .req_b_1       (req_b[1]),
        .req_op_1      (req_op[1]),
        .resp_valid_1  (resp_valid_1),
        .resp_ready_1  (resp_ready[1]),
        .resp_result_1 (resp_result_1),
        .resp_zero_1   (resp_zero_1),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_control   (alu_control),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero)
    );

    // External ALU being shared
    always_comb begin
        alu_result = 16'h0000;
        case (alu_control)
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = (alu_a < alu_b) ? 16'h0001 : 16'h0000;
            default: alu_result = alu_a + alu_b;
        endcase
        alu_zero = (alu_result == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ready_of(input int p);
        return (p == 0) ? req_ready_0 : req_ready_1;
    endfunction

    function automatic logic rvalid_of(input int p);
        return (p == 0) ? resp_valid_0 : resp_valid_1;
    endfunction

    function automatic logic [15:0] result_of(input int p);
        return (p == 0) ? resp_result_0 : resp_result_1;
    endfunction

    function automatic logic zero_of(input int p);
        return (p == 0) ? resp_zero_0 : resp_zero_1;
    endfunction

    // Full transaction on one port with resp_ready already high.
    // Entered and left at a negedge with the DUT in IDLE.
    task automatic do_op(input int p, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [15:0] exp_r, input logic exp_z);
        req_a[p]      = a;
        req_b[p]      = b;
        req_op[p]     = op;
        req_valid[p]  = 1'b1;
        resp_ready[p] = 1'b1;
        #1;
        check("req_ready_same_cycle", ready_of(p), 1'b1);
        check("req_ready_other", ready_of(1 - p), 1'b0);
        @(posedge clk);
        @(negedge clk);
        req_valid[p] = 1'b0;
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_control", alu_control, op);
        check("exec_resp_valid", rvalid_of(p), 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("resp_valid", rvalid_of(p), 1'b1);
        check("resp_result", result_of(p), exp_r);
        check("resp_zero", zero_of(p), exp_z);
        check("resp_valid_other", rvalid_of(1 - p), 1'b0);
        check("resp_req_ready", ready_of(p), 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("back_to_idle_valid", rvalid_of(p), 1'b0);
        resp_ready[p] = 1'b0;
    endtask

    initial begin
        int g;
        int exp_g [4];

        for (int i = 0; i < 2; i++) begin
            req_a[i]  = 16'h0;
            req_b[i]  = 16'h0;
            req_op[i] = 3'd0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid_0", resp_valid_0, 1'b0);
        check("rst_resp_valid_1", resp_valid_1, 1'b0);
        check("rst_resp_result", resp_result_0, 16'h0000);
        check("rst_resp_zero", resp_zero_1, 1'b0);
        check("rst_alu_a", alu_a, 16'h0000);
        check("rst_alu_b", alu_b, 16'h0000);
        check("rst_alu_control", alu_control, 3'd0);
        reset = 1'b0;

        // 5 - 3 on port 0
        do_op(0, 16'h0005, 16'h0003, 3'd1, 16'h0002, 1'b0);
        // 0x1234 - 0x1234 on port 1 gives zero
        do_op(1, 16'h1234, 16'h1234, 3'd1, 16'h0000, 1'b1);

        // Tie: both ports valid continuously
`ifdef ALU_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        req_a[0] = 16'h0001; req_b[0] = 16'h0001; req_op[0] = 3'd0;
        req_a[1] = 16'h0100; req_b[1] = 16'h0200; req_op[1] = 3'd0;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            g = exp_g[i];
            #1;
            check("tie_ready_0", req_ready_0, (g == 0));
            check("tie_ready_1", req_ready_1, (g == 1));
            @(posedge clk);
            @(negedge clk);
            check("tie_exec_ready", {req_ready_1, req_ready_0}, 2'b00);
            @(posedge clk);
            @(negedge clk);
            check("tie_resp_valid", rvalid_of(g), 1'b1);
            check("tie_resp_result", result_of(g), (g == 0) ? 16'h0002 : 16'h0300);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid  = 2'b00;
        resp_ready = 2'b00;

        // Backpressure on port 0 with a stalled request on port 1
        req_a[0] = 16'hFFFF; req_b[0] = 16'h0001; req_op[0] = 3'd4;
        req_valid[0] = 1'b1;
        #1;
        check("bp_req_ready_0", req_ready_0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_a[1] = 16'h0007; req_b[1] = 16'h0003; req_op[1] = 3'd2;
        req_valid[1] = 1'b1;
        #1;
        check("bp_exec_ready_1", req_ready_1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid_0", resp_valid_0, 1'b1);
            check("bp_resp_result", resp_result_0, 16'h0000);
            check("bp_resp_zero", resp_zero_0, 1'b1);
            check("bp_req_ready", {req_ready_1, req_ready_0}, 2'b00);
            check("bp_resp_valid_1", resp_valid_1, 1'b0);
            if (k < 4) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_released_valid", resp_valid_0, 1'b0);
        check("bp_stalled_wins", req_ready_1, 1'b1);
        resp_ready[0] = 1'b0;
        do_op(1, 16'h0007, 16'h0003, 3'd2, 16'h0003, 1'b0);

        // Reset while in EXEC
        req_a[0] = 16'h00AA; req_b[0] = 16'h0055; req_op[0] = 3'd3;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("rx_exec_alu_a", alu_a, 16'h00AA);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rx_resp_valid", {resp_valid_1, resp_valid_0}, 2'b00);
        check("rx_alu_a", alu_a, 16'h0000);
        check("rx_alu_b", alu_b, 16'h0000);
        check("rx_alu_control", alu_control, 3'd0);
        check("rx_resp_result", resp_result_1, 16'h0000);
        check("rx_resp_zero", resp_zero_0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Op code 7 executes as add
        do_op(0, 16'h0010, 16'h0020, 3'd7, 16'h0030, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
